// File: rtl/tap_pkg.sv
// Shared definitions for the scan-chain host.
// Contents:
//   WIDTH              bits per serial frame (start, 8 data bits LSB first, stop)
//   START / STOP       framing bit values
//   IDLE_TDI/IDLE_TMS  line levels driven while the chain is idle
//   state_t            host sequencer states
//   make_frame()       builds a serial frame from a byte (bit 0 goes out first)
package tap_pkg;

    localparam int   WIDTH    = 10;
    localparam logic START    = 1'b0;
    localparam logic STOP     = 1'b1;
    localparam logic IDLE_TDI = 1'b1;
    localparam logic IDLE_TMS = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_RECV,
        ST_TRAIL
    } state_t;

    function automatic logic [WIDTH-1:0] make_frame(input logic [7:0] b);
        return {STOP, b, START};
    endfunction

endpackage

// File: rtl/tck_gen.sv
// TCK divider for the scan-chain host.
// Ports:
//   clk   system clock
//   srst  synchronous active-high reset
//   en    run the divider; while low the counter and tck are held at 0
//   tck   registered test clock, starts low whenever en rises
//   rise  strobe: tck goes 0->1 at the end of this clk cycle
//   fall  strobe: tck goes 1->0 at the end of this clk cycle
module tck_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_reg;
    logic          tck_reg;
    logic          wrap;

    // The strobes are decoded from registered state so the host can act on
    // the same edge that moves tck.
    assign wrap = en && (cnt_reg == CW'(DIV - 1));
    assign rise = wrap && !tck_reg;
    assign fall = wrap && tck_reg;
    assign tck  = tck_reg;

    always_ff @(posedge clk) begin
        if (srst || !en) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (wrap) begin
            cnt_reg <= '0;
            tck_reg <= ~tck_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tap_host.sv
// Scan-chain host: sends an address frame and a data frame to a tap target,
// then collects the target's response frame.
// Ports:
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_start                 request a transaction (honoured only in IDLE)
//   i_address, i_data       target address and outbound byte, captured at start
//   i_tdo                   chain return line, sampled on TCK rise strobes
//   o_tck, o_tms, o_tdi     chain drive lines (tms/tdi move on fall strobes)
//   o_busy                  high from accepted start until back in IDLE
//   o_rx_data               response byte, held until the next accepted start
//   o_rx_valid, o_rx_err    response status pulses (at most one per transaction)
//   o_done                  end-of-transaction pulse
module tap_host
    import tap_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int PREAMBLE = 10,
    parameter int TIMEOUT  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_address,
    input  logic [7:0] i_data,
    input  logic       i_tdo,
    output logic       o_tck,
    output logic       o_tms,
    output logic       o_tdi,
    output logic       o_busy,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_err,
    output logic       o_done
);

    state_t             state_reg;
    logic [15:0]        cnt_reg;
    logic [15:0]        wait_cnt_reg;
    logic [WIDTH-1:0]   tx_shift_reg;
    logic [WIDTH-1:0]   data_frame_reg;
    logic               lead_reg;
    logic [7:0]         rx_shift_reg;
    logic [3:0]         rx_cnt_reg;
    logic               rx_started_reg;
    logic               busy_reg;
    logic               tms_reg;
    logic               tdi_reg;
    logic [7:0]         rx_data_reg;
    logic               rx_valid_reg;
    logic               rx_err_reg;
    logic               done_reg;
    logic               rise;
    logic               fall;

    tck_gen #(.DIV(DIV)) u_tck_gen (
        .clk  (i_clk),
        .srst (i_rst),
        .en   (busy_reg),
        .tck  (o_tck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            wait_cnt_reg   <= '0;
            tx_shift_reg   <= '0;
            data_frame_reg <= '0;
            lead_reg       <= 1'b0;
            rx_shift_reg   <= '0;
            rx_cnt_reg     <= '0;
            rx_started_reg <= 1'b0;
            busy_reg       <= 1'b0;
            tms_reg        <= IDLE_TMS;
            tdi_reg        <= IDLE_TDI;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_err_reg     <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A start seen while o_done is up is dropped so the
                    // caller always sees one quiet cycle between transactions.
                    if (i_start && !done_reg) begin
                        tx_shift_reg   <= make_frame(i_address);
                        data_frame_reg <= make_frame(i_data);
                        rx_data_reg    <= '0;
                        busy_reg       <= 1'b1;
                        cnt_reg        <= '0;
                        state_reg      <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (fall) begin
                        if (cnt_reg == 16'(PREAMBLE - 1)) begin
                            tdi_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b1, tx_shift_reg[WIDTH-1:1]};
                            cnt_reg      <= '0;
                            state_reg    <= ST_ADDR;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (fall) begin
                        if (cnt_reg == 16'(WIDTH - 1)) begin
                            tdi_reg   <= IDLE_TDI;
                            state_reg <= ST_GAP;
                        end else begin
                            tdi_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b1, tx_shift_reg[WIDTH-1:1]};
                            cnt_reg      <= cnt_reg + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (fall) begin
                        tx_shift_reg <= data_frame_reg;
                        lead_reg     <= 1'b1;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // DATA opens with one lead period (tms still low); its
                    // closing fall is the first fall of DATA, which raises
                    // tms together with the data start bit.
                    if (fall) begin
                        if (lead_reg) begin
                            lead_reg     <= 1'b0;
                            tms_reg      <= 1'b1;
                            tdi_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b1, tx_shift_reg[WIDTH-1:1]};
                            cnt_reg      <= '0;
                        end else if (cnt_reg == 16'(WIDTH - 1)) begin
                            tdi_reg        <= IDLE_TDI;
                            rx_started_reg <= 1'b0;
                            rx_cnt_reg     <= '0;
                            wait_cnt_reg   <= '0;
                            state_reg      <= ST_RECV;
                        end else begin
                            tdi_reg      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b1, tx_shift_reg[WIDTH-1:1]};
                            cnt_reg      <= cnt_reg + 16'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (rise) begin
                        if (!rx_started_reg) begin
                            if (i_tdo == START) begin
                                rx_started_reg <= 1'b1;
                            end else if (wait_cnt_reg == 16'(TIMEOUT - 1)) begin
                                rx_err_reg  <= 1'b1;
                                rx_data_reg <= '0;
                                cnt_reg     <= '0;
                                state_reg   <= ST_TRAIL;
                            end else begin
                                wait_cnt_reg <= wait_cnt_reg + 16'd1;
                            end
                        end else if (rx_cnt_reg == 4'd8) begin
                            rx_data_reg <= rx_shift_reg;
                            if (i_tdo == STOP) begin
                                rx_valid_reg <= 1'b1;
                            end else begin
                                rx_err_reg <= 1'b1;
                            end
                            cnt_reg   <= '0;
                            state_reg <= ST_TRAIL;
                        end else begin
                            rx_shift_reg <= {i_tdo, rx_shift_reg[7:1]};
                            rx_cnt_reg   <= rx_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_TRAIL: begin
                    // Entered on a rise: the first fall closes the last RECV
                    // period, the second closes the full trailing period.
                    if (fall) begin
                        if (cnt_reg == 16'd1) begin
                            tms_reg   <= IDLE_TMS;
                            tdi_reg   <= IDLE_TDI;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tms      = tms_reg;
    assign o_tdi      = tdi_reg;
    assign o_busy     = busy_reg;
    assign o_rx_data  = rx_data_reg;
    assign o_rx_valid = rx_valid_reg;
    assign o_rx_err   = rx_err_reg;
    assign o_done     = done_reg;

endmodule

// File: doc/tap_host.md
TAP_HOST -- requirements
Module: tap_host

Interface
REQ-001 Parameter DIV, default 4: i_clk cycles per TCK half-period; legal values >= 2.
REQ-002 Parameter PREAMBLE, default 10: idle TCK periods before each address frame.
REQ-003 Parameter TIMEOUT, default 16: TCK periods allowed in RECV for the response start bit.
REQ-004 i_clk  in  1  system clock; one clock domain; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_start  in  1  request a transaction; sampled only in IDLE.
REQ-007 i_address  in  8  target project address; captured at accepted start.
REQ-008 i_data  in  8  byte for the target's inbound port; captured at accepted start.
REQ-009 i_tdo  in  1  chain return line.
REQ-010 o_tck, o_tms, o_tdi  out  1 each  scan-chain drive lines.
REQ-011 o_busy  out  1  high from accepted start until return to IDLE.
REQ-012 o_rx_data  out  8  response byte; held until the next accepted start.
REQ-013 o_rx_valid, o_rx_err, o_done  out  1 each  one-i_clk-cycle pulses.

Function
REQ-014 Internal divider counts 0..DIV-1 only while busy; o_tck toggles when count = DIV-1, giving a fall strobe (1->0) and a rise strobe (0->1).
REQ-015 o_tdi and o_tms change only on the i_clk cycle of a fall strobe; i_tdo is registered only on the cycle of a rise strobe.
REQ-016 Frame: 10 bits LSB first: start 0, d[0]..d[7], stop 1.
REQ-017 States: IDLE, PRE, ADDR, GAP, DATA, RECV, TRAIL.
REQ-018 IDLE: o_tck=0, o_tms=0, o_tdi=1; i_start=1 latches inputs, clears o_rx_data, asserts o_busy and enters PRE on the next cycle with o_tck starting low.
REQ-019 PRE: PREAMBLE TCK periods, tdi=1, tms=0.
REQ-020 ADDR: address frame over 10 periods, tms=0.
REQ-021 GAP: exactly 1 period, tdi=1, tms=0, so the target's address-capture edge sees TMS low.
REQ-022 DATA: tms=1 from the first fall of DATA; data frame over 10 periods.
REQ-023 RECV: tdi=1, tms=1; sampled bits are discarded until the first 0 (start bit); the next 8 samples fill o_rx_data LSB first; the 10th sample is the stop bit.
REQ-024 Stop bit = 1 -> o_rx_valid pulse; stop bit = 0 -> o_rx_err pulse with o_rx_data still updated; either case enters TRAIL.
REQ-025 No start bit within TIMEOUT rise strobes of entering RECV -> o_rx_err pulse, o_rx_data = 0, enter TRAIL.
REQ-026 TRAIL: 1 period with tms=1 and tdi=1; at its end tms=0, tck stays low, o_done pulses, o_busy drops, return to IDLE.
REQ-027 i_start while busy is ignored; i_start on the o_done cycle is ignored; the next start is accepted one cycle later.
REQ-028 At most one of o_rx_valid and o_rx_err pulses per transaction; o_done pulses exactly once per transaction.
REQ-029 Nominal duration with the response start bit found on the 2nd rise is (PREAMBLE + 34) TCK periods.

Reset
REQ-030 i_rst returns the block to IDLE on the next i_clk edge: o_tck=0, o_tms=0, o_tdi=1, o_busy=0, o_rx_data=0, all pulses 0, divider=0.
REQ-031 Reset mid-transaction aborts it with no o_done, o_rx_valid or o_rx_err pulse; i_rst overrides i_start.

Structure
REQ-032 Shared package tap_pkg: frame WIDTH=10, START=0, STOP=1, IDLE pattern, and the state enumeration.
REQ-033 One sub-module, tck_gen: the DIV counter producing o_tck and the rise and fall strobes.
REQ-034 All outputs are registered; no combinational path from i_tdo to any output.

Verification
REQ-035 Loopback through one tap instance at address 0x5A with outbound 0xC3; start with address 0x5A, data 0x81 -> target inbound = 0x81 during DATA/RECV, o_rx_valid, o_rx_data = 0xC3, o_done.
REQ-036 Same bench, start with address 0x33 -> tap bypasses; o_rx_err after TIMEOUT=16 rise strobes, o_rx_data = 0x00, o_done.
REQ-037 i_tdo forced to 1 for the whole transaction -> timeout path; o_tms ends at 0.
REQ-038 i_tdo model drives start 0, byte 0xFF, stop 0 -> o_rx_err with o_rx_data = 0xFF.
REQ-039 i_rst asserted for 1 cycle in DATA -> next cycle o_tck=0, o_tms=0, o_tdi=1, o_busy=0, and no pulse follows.
REQ-040 i_start held high for 3 transactions with DIV=2 -> o_tck period is 4 i_clk cycles, and exactly 3 o_done pulses are spaced by the REQ-029 length + 1 idle cycle.
